seq_bit_tx: RTL
===============

# seq_bit_tx

Serial bit-sequence transmitter that produces the single-bit stream consumed by the team's sequence detectors. It accepts a parallel pattern (up to MAX_LEN bits, plus a repeat count) through a valid/ready load handshake. It then drives the pattern MSB-first on `out_bit`, one bit per clock, qualified by `out_valid`. It sits between a test or control master and any `inp_bit`-style detector input. It is used to generate stimulus streams such as 1011, overlapping 1011011, and runs of repeated patterns.

## Interface
- `MAX_LEN`, 16, maximum pattern length in bits
- `LEN_W`, 5, width of the length field; must hold MAX_LEN (clog2(MAX_LEN+1))
- `REP_W`, 4, width of the repeat-count field
- `clk` input 1: single clock; all state changes on its rising edge
- `reset` input 1: asynchronous, active-high reset
- `load_valid` input 1: master offers a pattern
- `load_ready` output 1: block can accept a pattern
- `load_pattern` input MAX_LEN: pattern bits; bit [len-1] is sent first
- `load_len` input LEN_W: number of pattern bits to send, 0..MAX_LEN
- `load_repeat` input REP_W: number of extra repetitions (0 means send once)
- `abort` input 1: synchronous request to stop the current transmission
- `out_bit` output 1: serial data
- `out_valid` output 1: `out_bit` carries a pattern bit this cycle
- `busy` output 1: a transmission is in progress (SHIFT or DONE)
- `done` output 1: one-cycle pulse at the end of the transmission

## Operation
- **States:** IDLE, SHIFT, DONE. The state is registered and the next-state logic is combinational.
- **IDLE**
  - `load_ready`=1.
  - On `load_valid`&`load_ready` at an edge, the block captures pattern, length and repeat.
  - If len≠0 it goes to SHIFT with bit index = len-1.
  - If len=0 it goes to DONE.
- **Length clamp:** `load_len`>MAX_LEN is clamped to MAX_LEN.
- **SHIFT**
  - `out_valid`=1 and `out_bit`=pattern[index].
  - Each cycle the index decrements.
  - At index 0:
    - If rep_left>0: rep_left decrements and index reloads to len-1. Repetitions are back-to-back, with no gap cycle.
    - Otherwise: go to DONE.
- **DONE:** `done`=1 and `out_valid`=0 for exactly one cycle, then IDLE.
- **abort:** sampled only in SHIFT.
  - The bit shown in the abort cycle is still valid.
  - The next state is DONE regardless of index or repeat count.
  - In IDLE and DONE, abort is ignored.
- **Outputs when `out_valid`=0:** `out_bit` is forced to 0.
- **Loads while busy:** `load_ready`=0, so `load_valid` is ignored and the held pattern is not disturbed.
- **Output sourcing:** all outputs are driven from registers or from decodes of registered state only. There is no combinational path from inputs to outputs.
- **Total bits sent:** len×(repeat+1), up to MAX_LEN×2^REP_W.

## Timing
- **Reset:** asynchronous assertion forces state=IDLE and clears index, rep_left and pattern, immediately and without a clock.
  - Output values during reset: `load_ready`=1, `out_valid`=0, `out_bit`=0, `busy`=0, `done`=0.
  - A transmission in progress is discarded. No `done` is issued for it.
  - Release is at a clock edge; the first accept is possible on the first edge after release.
- **Load latency:** the handshake at edge k gives the first valid bit in cycle k+1, i.e. after edge k.
- **Transmission timing:**
  - The last bit is in cycle k+N, where N = len×(repeat+1).
  - `done` is in cycle k+N+1.
  - `load_ready` returns in cycle k+N+2.
- **Zero length:** len=0 gives `done` in cycle k+1 and `load_ready` in cycle k+2.
- **Abort timing:** abort asserted in a SHIFT cycle c gives `done` in cycle c+1 and IDLE in cycle c+2.
- **Throughput:** one accepted pattern per N+2 cycles at most.
- **busy:** `busy` = ~`load_ready`.

## Structure
- **Package `seq_bit_tx_pkg`**
  - State encodings: IDLE=0, SHIFT=1, DONE=2, in a 2-bit type.
  - Default parameter constants MAX_LEN, LEN_W and REP_W.
- **Sub-module `seq_bit_tx_shreg`**
  - Holds the pattern register and bit index, with load/decrement/reload controls and the `out_bit` mux.
  - The top level holds the FSM, the repeat counter and the handshake.

## Test plan
- **Basic 1011:** pattern=4'b1011, len=4, repeat=0.
  - Required: `out_bit` 1,0,1,1 with `out_valid`=1 in cycles k+1..k+4.
  - Required: `done` in k+5 and `load_ready` in k+6.
- **Repeat:** pattern 1011, len=4, repeat=2.
  - Required: 12 contiguous valid bits 101110111011, with no gap between repetitions.
  - Required: `done` in k+13.
- **Edge lengths:**
  - len=0: `done` in k+1 and no `out_valid` at all.
  - len=20 with MAX_LEN=16: 16 bits are sent, pattern[15] first.
- **Abort:** abort in the 3rd bit cycle of len=8.
  - Required: exactly 3 valid bits, `done` on the next cycle, then IDLE.
- **Load while busy:** `load_valid` held with a new pattern during SHIFT.
  - Required: not accepted and the current bits are unchanged.
  - Required: the new pattern is accepted the cycle `load_ready` rises.
- **Reset mid-transmission:** `reset` asserted between edges during SHIFT.
  - Required: outputs go immediately to `out_valid`=0, `busy`=0, `load_ready`=1, and no `done` follows.
  - Required: after release, a fresh 1011 load transmits correctly.

Source files
------------

// File: rtl/seq_bit_tx_pkg.sv
// Shared types and default sizing for the serial bit-sequence transmitter.
package seq_bit_tx_pkg;

  localparam int unsigned DefMaxLen = 16;
  localparam int unsigned DefLenW   = 5;
  localparam int unsigned DefRepW   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_bit_tx_shreg.sv
// Pattern store and bit index for seq_bit_tx; selects the current serial bit MSB-first.
module seq_bit_tx_shreg
  import seq_bit_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = DefLenW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic               dec_en,
  input  logic               reload_en,
  input  logic               bit_en,
  output logic               idx_zero,
  output logic               out_bit
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    if (load_en) begin
      pattern_d = load_pattern;
      len_d     = load_len;
      // A zero length wraps here, but the FSM never shifts in that case.
      idx_d     = IdxW'(load_len - LEN_W'(1));
    end else if (reload_en) begin
      idx_d = IdxW'(len_q - LEN_W'(1));
    end else if (dec_en) begin
      idx_d = idx_q - IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
    end
  end

  assign idx_zero = (idx_q == '0);
  assign out_bit  = bit_en & pattern_q[idx_q];

endmodule

// File: rtl/seq_bit_tx.sv
// Serial bit-sequence transmitter: loads a pattern via valid/ready and shifts it out
// MSB-first, repeated back-to-back, with abort and a one-cycle done pulse.
module seq_bit_tx
  import seq_bit_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned REP_W   = DefRepW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_repeat,
  input  logic               abort,
  output logic               out_bit,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [LEN_W-1:0]   len_clamped;
  logic               load_en, dec_en, reload_en, idx_zero;

  assign len_clamped = (load_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : load_len;

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    load_en   = 1'b0;
    dec_en    = 1'b0;
    reload_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          load_en = 1'b1;
          rep_d   = load_repeat;
          state_d = (len_clamped != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StDone;
        end else if (idx_zero) begin
          // Next repetition starts on the following cycle with no gap.
          if (rep_q != '0) begin
            rep_d     = rep_q - REP_W'(1);
            reload_en = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else begin
          dec_en = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
    end
  end

  seq_bit_tx_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_pattern (load_pattern),
    .load_len     (len_clamped),
    .dec_en       (dec_en),
    .reload_en    (reload_en),
    .bit_en       (out_valid),
    .idx_zero     (idx_zero),
    .out_bit      (out_bit)
  );

  assign load_ready = (state_q == StIdle);
  assign busy       = ~load_ready;
  assign out_valid  = (state_q == StShift);
  assign done       = (state_q == StDone);

endmodule
